ysyx_25020037_wb_arb: RTL and testbench

Write-back arbiter and scoreboard for the general-purpose register file. It shares the single register-file write port between the execute unit (EXU) and the load/store unit (LSU) using round-robin arbitration and a registered write stage. It also tracks outstanding writes per register so decode can stall on read-after-write hazards. It sits between EXU/LSU and the register file's `gpr_waddr`/`gpr_wdata`/`gpr_wen` inputs.

---
 rtl/ysyx_25020037_wb_arb_if.sv | 47 ++++
 rtl/ysyx_25020037_wb_arb.sv | 106 ++++++++++
 tb/tb_ysyx_25020037_wb_arb.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_25020037_wb_arb_if.sv
// ============================================================================
// Module      : ysyx_25020037_wb_arb_if
// Description : Issue, write-back request and register-file write bundle
//               for the write-back arbiter / scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ysyx_25020037_wb_arb_if;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        iss_ready;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        exu_valid;
  logic [4:0]  exu_rd;
  logic [31:0] exu_data;
  logic        exu_ready;
  logic        lsu_valid;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        lsu_ready;
  logic        gpr_wen;
  logic [4:0]  gpr_waddr;
  logic [31:0] gpr_wdata;
  logic        sb_err;

  modport master (
    output iss_valid, iss_rd, rs1, rs2,
    output exu_valid, exu_rd, exu_data,
    output lsu_valid, lsu_rd, lsu_data,
    input  iss_ready, rs1_busy, rs2_busy, exu_ready, lsu_ready,
    input  gpr_wen, gpr_waddr, gpr_wdata, sb_err
  );

  modport slave (
    input  iss_valid, iss_rd, rs1, rs2,
    input  exu_valid, exu_rd, exu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    output iss_ready, rs1_busy, rs2_busy, exu_ready, lsu_ready,
    output gpr_wen, gpr_waddr, gpr_wdata, sb_err
  );
endinterface

`default_nettype wire

// File: rtl/ysyx_25020037_wb_arb.sv
// ============================================================================
// Module      : ysyx_25020037_wb_arb
// Description : Round-robin EXU/LSU write-back arbiter with a registered
//               register-file write stage and a per-register RAW scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_25020037_wb_arb #(
  parameter int SB_W = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  ysyx_25020037_wb_arb_if.slave      bus
);

  localparam logic [SB_W-1:0] C_CNT_SAT = {SB_W{1'b1}};
  localparam logic [SB_W-1:0] C_CNT_ONE = SB_W'(1);

  logic              r_last;
  logic              r_wen;
  logic [4:0]        r_waddr;
  logic [31:0]       r_wdata;
  logic              r_err;
  logic [SB_W-1:0]   r_cnt [32];

  logic              w_exu_gnt;
  logic              w_lsu_gnt;
  logic              w_iss_ready;
  logic              w_iss_fire;
  logic              w_commit_err;
  logic [31:1]       w_inc;
  logic [31:1]       w_dec;

  // r_last = 1 means LSU won last, so EXU gets priority on contention
  assign w_exu_gnt = bus.exu_valid & (~bus.lsu_valid | r_last);
  assign w_lsu_gnt = bus.lsu_valid & (~bus.exu_valid | ~r_last);

  assign w_iss_ready = (bus.iss_rd == 5'd0) | (r_cnt[bus.iss_rd] != C_CNT_SAT);
  assign w_iss_fire  = bus.iss_valid & w_iss_ready & (bus.iss_rd != 5'd0);

  always_comb begin
    w_inc = '0;
    w_dec = '0;
    for (int i = 1; i < 32; i++) begin
      w_inc[i] = w_iss_fire & (bus.iss_rd == 5'(i));
      w_dec[i] = r_wen & (r_waddr == 5'(i));
    end
  end

  // A commit on a register with nothing pending is a write-back without issue
  assign w_commit_err = r_wen & (r_cnt[r_waddr] == '0)
                      & ~(w_iss_fire & (bus.iss_rd == r_waddr));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last  <= 1'b1;
      r_wen   <= 1'b0;
      r_waddr <= 5'd0;
      r_wdata <= 32'd0;
      r_err   <= 1'b0;
      for (int i = 0; i < 32; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      if (w_exu_gnt) begin
        r_wen   <= (bus.exu_rd != 5'd0);
        r_waddr <= bus.exu_rd;
        r_wdata <= bus.exu_data;
        r_last  <= 1'b0;
      end else if (w_lsu_gnt) begin
        r_wen   <= (bus.lsu_rd != 5'd0);
        r_waddr <= bus.lsu_rd;
        r_wdata <= bus.lsu_data;
        r_last  <= 1'b1;
      end else begin
        r_wen   <= 1'b0;
      end

      if (w_commit_err) begin
        r_err <= 1'b1;
      end

      for (int i = 1; i < 32; i++) begin
        if (w_inc[i] && !w_dec[i]) begin
          r_cnt[i] <= r_cnt[i] + C_CNT_ONE;
        end else if (w_dec[i] && !w_inc[i] && (r_cnt[i] != '0)) begin
          r_cnt[i] <= r_cnt[i] - C_CNT_ONE;
        end
      end
    end
  end

  assign bus.exu_ready = w_exu_gnt;
  assign bus.lsu_ready = w_lsu_gnt;
  assign bus.iss_ready = w_iss_ready;
  assign bus.rs1_busy  = (bus.rs1 != 5'd0) & (r_cnt[bus.rs1] != '0);
  assign bus.rs2_busy  = (bus.rs2 != 5'd0) & (r_cnt[bus.rs2] != '0);
  assign bus.gpr_wen   = r_wen;
  assign bus.gpr_waddr = r_waddr;
  assign bus.gpr_wdata = r_wdata;
  assign bus.sb_err    = r_err;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_25020037_wb_arb.sv
// ============================================================================
// Module      : tb_ysyx_25020037_wb_arb
// Description : Directed and randomized bench for the write-back arbiter,
//               compared against a pending-count reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ysyx_25020037_wb_arb;

  localparam int SB_W = 2;
  localparam int SAT  = (1 << SB_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ysyx_25020037_wb_arb_if bus();

  ysyx_25020037_wb_arb #(.SB_W(SB_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pending writes per register, arbitration pointer, staged write
  int          m_cnt [32];
  bit          m_last;
  bit          m_wen;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  bit          m_err;
  bit          m_ge;
  bit          m_gl;

  function automatic bit exp_exu_rdy();
    return bus.exu_valid && (!bus.lsu_valid || m_last);
  endfunction

  function automatic bit exp_lsu_rdy();
    return bus.lsu_valid && (!bus.exu_valid || !m_last);
  endfunction

  function automatic bit exp_iss_rdy();
    return (bus.iss_rd == 5'd0) || (m_cnt[bus.iss_rd] < SAT);
  endfunction

  function automatic bit exp_busy(input logic [4:0] r);
    return (r != 5'd0) && (m_cnt[r] > 0);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_cnt[i] = 0;
    m_last = 1'b1; m_wen = 1'b0; m_waddr = '0; m_wdata = '0;
    m_err = 1'b0; m_ge = 1'b0; m_gl = 1'b0;
  endtask

  task automatic model_step();
    int inc_rd;
    int com_rd;
    inc_rd = (bus.iss_valid && exp_iss_rdy() && bus.iss_rd != 5'd0) ? int'(bus.iss_rd) : 0;
    com_rd = m_wen ? int'(m_waddr) : 0;
    if (com_rd != 0 && com_rd != inc_rd) begin
      if (m_cnt[com_rd] == 0) m_err = 1'b1;
      else m_cnt[com_rd] = m_cnt[com_rd] - 1;
    end
    if (inc_rd != 0 && inc_rd != com_rd) m_cnt[inc_rd] = m_cnt[inc_rd] + 1;
    m_ge = exp_exu_rdy();
    m_gl = exp_lsu_rdy();
    if (m_ge) begin
      m_wen = (bus.exu_rd != 5'd0); m_waddr = bus.exu_rd; m_wdata = bus.exu_data; m_last = 1'b0;
    end else if (m_gl) begin
      m_wen = (bus.lsu_rd != 5'd0); m_waddr = bus.lsu_rd; m_wdata = bus.lsu_data; m_last = 1'b1;
    end else begin
      m_wen = 1'b0;
    end
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.iss_valid = 1'b0; bus.exu_valid = 1'b0; bus.lsu_valid = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    bus.rs1 = 5'd7; bus.rs2 = 5'd0; bus.iss_rd = 5'd7;
    #1;
    n_checks++; if (bus.gpr_wen !== 1'b0) begin n_fail++; $display("FAIL reset_wen: got %0h expected 0", bus.gpr_wen); end
    n_checks++; if (bus.gpr_waddr !== 5'd0) begin n_fail++; $display("FAIL reset_waddr: got %0h expected 0", bus.gpr_waddr); end
    n_checks++; if (bus.gpr_wdata !== 32'd0) begin n_fail++; $display("FAIL reset_wdata: got %0h expected 0", bus.gpr_wdata); end
    n_checks++; if (bus.sb_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %0h expected 0", bus.sb_err); end
    n_checks++; if (bus.rs1_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0h expected 0", bus.rs1_busy); end
    n_checks++; if (bus.iss_ready !== 1'b1) begin n_fail++; $display("FAIL reset_iss_ready: got %0h expected 1", bus.iss_ready); end
  endtask

  task automatic test_alternate();
    logic [4:0] rds [4];
    rds[0] = 5'd1; rds[1] = 5'd1; rds[2] = 5'd2; rds[3] = 5'd2;
    for (int k = 0; k < 4; k++) begin
      bus.iss_valid = 1'b1; bus.iss_rd = rds[k];
      #1;
      n_checks++; if (bus.iss_ready !== 1'b1) begin n_fail++; $display("FAIL alt_issue: got %0h expected 1", bus.iss_ready); end
      tick();
    end
    bus.iss_valid = 1'b0;
    bus.exu_rd = 5'd1; bus.exu_data = 32'h1111_1111;
    bus.lsu_rd = 5'd2; bus.lsu_data = 32'h2222_2222;
    for (int k = 0; k < 4; k++) begin
      bus.exu_valid = 1'b1; bus.lsu_valid = 1'b1;
      #1;
      n_checks++; if (bus.exu_ready !== ((k % 2) == 0)) begin n_fail++; $display("FAIL alt_exu_ready[%0d]: got %0h expected %0h", k, bus.exu_ready, (k % 2) == 0); end
      n_checks++; if (bus.lsu_ready !== ((k % 2) == 1)) begin n_fail++; $display("FAIL alt_lsu_ready[%0d]: got %0h expected %0h", k, bus.lsu_ready, (k % 2) == 1); end
      if (k > 0) begin
        n_checks++; if (bus.gpr_waddr !== (((k - 1) % 2 == 0) ? 5'd1 : 5'd2) || bus.gpr_wen !== 1'b1) begin
          n_fail++; $display("FAIL alt_waddr[%0d]: got wen=%0h addr=%0d expected wen=1 addr=%0d", k, bus.gpr_wen, bus.gpr_waddr, ((k - 1) % 2 == 0) ? 1 : 2); end
      end
      tick();
    end
    idle();
    bus.rs1 = 5'd1; bus.rs2 = 5'd2;
    #1;
    n_checks++; if (bus.gpr_waddr !== 5'd2 || bus.gpr_wdata !== 32'h2222_2222) begin n_fail++; $display("FAIL alt_last_write: got %0d/%0h expected 2/22222222", bus.gpr_waddr, bus.gpr_wdata); end
    tick();
    #1;
    n_checks++; if (bus.rs1_busy !== 1'b0 || bus.rs2_busy !== 1'b0) begin n_fail++; $display("FAIL alt_busy_clear: got %0h%0h expected 00", bus.rs1_busy, bus.rs2_busy); end
  endtask

  task automatic test_single_exu();
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd5; bus.rs1 = 5'd5;
    #1; tick();
    bus.iss_valid = 1'b0;
    bus.exu_valid = 1'b1; bus.exu_rd = 5'd5; bus.exu_data = 32'hDEAD_BEEF;
    #1;
    n_checks++; if (bus.exu_ready !== 1'b1 || bus.lsu_ready !== 1'b0) begin n_fail++; $display("FAIL single_ready: got %0h%0h expected 10", bus.exu_ready, bus.lsu_ready); end
    n_checks++; if (bus.rs1_busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_pre: got %0h expected 1", bus.rs1_busy); end
    tick();
    bus.exu_valid = 1'b0;
    #1;
    n_checks++; if (bus.gpr_wen !== 1'b1 || bus.gpr_waddr !== 5'd5 || bus.gpr_wdata !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL single_write: got %0h/%0d/%0h expected 1/5/deadbeef", bus.gpr_wen, bus.gpr_waddr, bus.gpr_wdata); end
    n_checks++; if (bus.rs1_busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_commit: got %0h expected 1", bus.rs1_busy); end
    tick();
    #1;
    n_checks++; if (bus.gpr_wen !== 1'b0 || bus.gpr_wdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_after: got %0h/%0h expected 0/deadbeef", bus.gpr_wen, bus.gpr_wdata); end
    n_checks++; if (bus.rs1_busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_post: got %0h expected 0", bus.rs1_busy); end
  endtask

  task automatic test_saturate();
    bus.rs1 = 5'd7;
    for (int k = 0; k < 4; k++) begin
      bus.iss_valid = 1'b1; bus.iss_rd = 5'd7;
      #1;
      n_checks++; if (bus.iss_ready !== (k < 3)) begin n_fail++; $display("FAIL sat_iss_ready[%0d]: got %0h expected %0h", k, bus.iss_ready, k < 3); end
      if (k > 0) begin
        n_checks++; if (bus.rs1_busy !== 1'b1) begin n_fail++; $display("FAIL sat_busy_issue[%0d]: got %0h expected 1", k, bus.rs1_busy); end
      end
      tick();
    end
    bus.iss_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.exu_valid = (k < 3); bus.exu_rd = 5'd7; bus.exu_data = 32'(k);
      #1;
      n_checks++; if (bus.rs1_busy !== 1'b1) begin n_fail++; $display("FAIL sat_busy_wb[%0d]: got %0h expected 1", k, bus.rs1_busy); end
      tick();
    end
    #1;
    n_checks++; if (bus.rs1_busy !== 1'b0 || bus.gpr_wen !== 1'b0) begin n_fail++; $display("FAIL sat_busy_clear: got busy=%0h wen=%0h expected 0/0", bus.rs1_busy, bus.gpr_wen); end
  endtask

  task automatic test_same_cycle();
    bus.rs2 = 5'd9;
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd9;
    #1; tick();
    bus.iss_valid = 1'b0;
    bus.exu_valid = 1'b1; bus.exu_rd = 5'd9; bus.exu_data = 32'h99;
    #1; tick();
    bus.exu_valid = 1'b0;
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd9;
    #1;
    n_checks++; if (bus.gpr_wen !== 1'b1 || bus.gpr_waddr !== 5'd9 || bus.iss_ready !== 1'b1) begin
      n_fail++; $display("FAIL same_setup: got wen=%0h addr=%0d iss_ready=%0h expected 1/9/1", bus.gpr_wen, bus.gpr_waddr, bus.iss_ready); end
    tick();
    bus.iss_valid = 1'b0;
    #1;
    n_checks++; if (bus.rs2_busy !== 1'b1) begin n_fail++; $display("FAIL same_busy: got %0h expected 1", bus.rs2_busy); end
    n_checks++; if (bus.sb_err !== 1'b0) begin n_fail++; $display("FAIL same_err: got %0h expected 0", bus.sb_err); end
    bus.exu_valid = 1'b1;
    tick();
    bus.exu_valid = 1'b0;
    #1; tick();
    #1;
    n_checks++; if (bus.rs2_busy !== 1'b0) begin n_fail++; $display("FAIL same_busy_clear: got %0h expected 0", bus.rs2_busy); end
  endtask

  task automatic test_rd0();
    bus.rs1 = 5'd0;
    bus.exu_valid = 1'b1; bus.exu_rd = 5'd0; bus.exu_data = 32'h1234;
    #1;
    n_checks++; if (bus.exu_ready !== 1'b1) begin n_fail++; $display("FAIL rd0_ready: got %0h expected 1", bus.exu_ready); end
    tick();
    bus.exu_valid = 1'b0;
    #1;
    n_checks++; if (bus.gpr_wen !== 1'b0 || bus.gpr_wdata !== 32'h1234) begin n_fail++; $display("FAIL rd0_write: got %0h/%0h expected 0/1234", bus.gpr_wen, bus.gpr_wdata); end
    n_checks++; if (bus.sb_err !== 1'b0 || bus.rs1_busy !== 1'b0) begin n_fail++; $display("FAIL rd0_state: got err=%0h busy=%0h expected 0/0", bus.sb_err, bus.rs1_busy); end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if (!bus.exu_valid || m_ge) begin
        bus.exu_valid = 1'($urandom_range(0, 1)); bus.exu_rd = 5'($urandom_range(0, 7)); bus.exu_data = $urandom;
      end
      if (!bus.lsu_valid || m_gl) begin
        bus.lsu_valid = 1'($urandom_range(0, 1)); bus.lsu_rd = 5'($urandom_range(0, 7)); bus.lsu_data = $urandom;
      end
      bus.iss_valid = 1'($urandom_range(0, 1)); bus.iss_rd = 5'($urandom_range(0, 7));
      bus.rs1 = 5'($urandom_range(0, 7)); bus.rs2 = 5'($urandom_range(0, 7));
      #1;
      n_checks++; if (bus.exu_ready !== exp_exu_rdy()) begin n_fail++; $display("FAIL rnd_exu_ready c%0d: got %0h expected %0h", c, bus.exu_ready, exp_exu_rdy()); end
      n_checks++; if (bus.lsu_ready !== exp_lsu_rdy()) begin n_fail++; $display("FAIL rnd_lsu_ready c%0d: got %0h expected %0h", c, bus.lsu_ready, exp_lsu_rdy()); end
      n_checks++; if (bus.iss_ready !== exp_iss_rdy()) begin n_fail++; $display("FAIL rnd_iss_ready c%0d: got %0h expected %0h", c, bus.iss_ready, exp_iss_rdy()); end
      n_checks++; if (bus.rs1_busy !== exp_busy(bus.rs1)) begin n_fail++; $display("FAIL rnd_rs1_busy c%0d: got %0h expected %0h", c, bus.rs1_busy, exp_busy(bus.rs1)); end
      n_checks++; if (bus.rs2_busy !== exp_busy(bus.rs2)) begin n_fail++; $display("FAIL rnd_rs2_busy c%0d: got %0h expected %0h", c, bus.rs2_busy, exp_busy(bus.rs2)); end
      n_checks++; if (bus.gpr_wen !== m_wen) begin n_fail++; $display("FAIL rnd_wen c%0d: got %0h expected %0h", c, bus.gpr_wen, m_wen); end
      n_checks++; if (bus.gpr_waddr !== m_waddr) begin n_fail++; $display("FAIL rnd_waddr c%0d: got %0d expected %0d", c, bus.gpr_waddr, m_waddr); end
      n_checks++; if (bus.gpr_wdata !== m_wdata) begin n_fail++; $display("FAIL rnd_wdata c%0d: got %0h expected %0h", c, bus.gpr_wdata, m_wdata); end
      n_checks++; if (bus.sb_err !== m_err) begin n_fail++; $display("FAIL rnd_err c%0d: got %0h expected %0h", c, bus.sb_err, m_err); end
      tick();
    end
    idle();
  endtask

  task automatic test_sb_err();
    do_reset();
    bus.rs1 = 5'd3; bus.iss_rd = 5'd3;
    bus.exu_valid = 1'b1; bus.exu_rd = 5'd3; bus.exu_data = 32'h33;
    #1; tick();
    bus.exu_valid = 1'b0;
    #1;
    n_checks++; if (bus.gpr_wen !== 1'b1 || bus.sb_err !== 1'b0) begin n_fail++; $display("FAIL err_pre: got wen=%0h err=%0h expected 1/0", bus.gpr_wen, bus.sb_err); end
    tick();
    #1;
    n_checks++; if (bus.sb_err !== 1'b1) begin n_fail++; $display("FAIL err_set: got %0h expected 1", bus.sb_err); end
    for (int k = 0; k < 3; k++) tick();
    #1;
    n_checks++; if (bus.sb_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %0h expected 1", bus.sb_err); end
    n_checks++; if (bus.rs1_busy !== 1'b0 || bus.iss_ready !== 1'b1) begin n_fail++; $display("FAIL err_cnt_zero: got busy=%0h iss_ready=%0h expected 0/1", bus.rs1_busy, bus.iss_ready); end
  endtask

  task automatic test_reset_mid();
    bus.rs1 = 5'd4; bus.rs2 = 5'd4;
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd4;
    #1; tick();
    bus.iss_valid = 1'b0;
    bus.exu_valid = 1'b1; bus.exu_rd = 5'd4; bus.exu_data = 32'h44;
    #1; tick();
    idle();
    #1;
    n_checks++; if (bus.gpr_wen !== 1'b1 || bus.rs1_busy !== 1'b1) begin n_fail++; $display("FAIL mid_staged: got wen=%0h busy=%0h expected 1/1", bus.gpr_wen, bus.rs1_busy); end
    rst = 1'b0;
    #1;
    n_checks++; if (bus.gpr_wen !== 1'b0 || bus.gpr_waddr !== 5'd0) begin n_fail++; $display("FAIL mid_wen: got %0h/%0d expected 0/0", bus.gpr_wen, bus.gpr_waddr); end
    n_checks++; if (bus.rs1_busy !== 1'b0 || bus.rs2_busy !== 1'b0 || bus.sb_err !== 1'b0) begin
      n_fail++; $display("FAIL mid_state: got busy=%0h%0h err=%0h expected 00/0", bus.rs1_busy, bus.rs2_busy, bus.sb_err); end
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++; if (bus.gpr_wen !== 1'b0 || bus.rs1_busy !== 1'b0) begin n_fail++; $display("FAIL mid_release: got wen=%0h busy=%0h expected 0/0", bus.gpr_wen, bus.rs1_busy); end
  endtask

  initial begin
    bus.rs1 = '0; bus.rs2 = '0; bus.iss_rd = '0;
    bus.exu_rd = '0; bus.exu_data = '0; bus.lsu_rd = '0; bus.lsu_data = '0;
    do_reset();
    test_reset();
    test_alternate();
    test_single_exu();
    test_saturate();
    test_same_cycle();
    test_rd0();
    test_random();
    test_sb_err();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
